// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// Owns the PC and issues one request at a time to instruction memory.
// Returned words are buffered with their PC in a 2-entry queue whose head
// feeds the issue register. A redirect flushes the queue, retargets the PC
// and squashes any wrong-path response still in flight.
module fetch_stage #(
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        INSTR_W     = 32,
  parameter int unsigned        INSTR_BYTES = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no request on the bus
    S_REQ  = 2'd1,  // request presented, waiting for grant
    S_WAIT = 2'd2   // granted, waiting for read data
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

  // Control state
  state_t             state_q;
  state_t             state_d;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  issued_pc_q;  // PC of the request currently in flight
  logic               drop_q;       // in-flight response belongs to a squashed path

  // Queue state
  logic [INSTR_W-1:0] q_instr [2];
  logic [ADDR_W-1:0]  q_pc    [2];
  logic               rd_ptr_q;
  logic               wr_ptr_q;
  logic [1:0]         count_q;

  // Per-cycle decode
  logic               gnt;
  logic               rsp;
  logic               push;
  logic               pop;
  logic [1:0]         count_after;
  logic               credit_now;
  logic               credit_after;
  logic               head_valid;

  // Decode the memory handshake and queue occupancy for this cycle.
  always_comb begin
    gnt          = (state_q == S_REQ)  && imem_gnt;
    rsp          = (state_q == S_WAIT) && imem_rvalid;
    head_valid   = (count_q != 2'd0);
    pop          = head_valid && !stall;
    // A response is kept only if it is on the current path and no redirect
    // is flushing the queue on this same edge.
    push         = rsp && !drop_q && !redirect_valid;
    count_after  = count_q + {1'b0, push} - {1'b0, pop};
    // In IDLE nothing is outstanding, so credit is purely queue occupancy.
    credit_now   = (count_q < 2'd2);
    // Leaving WAIT the outstanding request has just retired, so credit is
    // judged on the occupancy after this edge's push and pop.
    credit_after = (count_after < 2'd2);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect takes priority over every other transition.
  always_comb begin
    // NOTE: defaulting every combinational output first keeps this block free
    // of inferred latches on paths that do not assign it.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!halt && credit_now && !redirect_valid) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          // Granted requests must still retire; ungranted ones are withdrawn.
          state_d = gnt ? S_WAIT : S_IDLE;
        end else if (gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp) begin
          if (redirect_valid) begin
            state_d = S_IDLE;
          end else if (!halt && credit_after) begin
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs: bus request from state, queue head from occupancy.
  always_comb begin
    imem_req    = (state_q == S_REQ);
    imem_addr   = pc_q;
    instr_valid = head_valid;
    instr       = head_valid ? q_instr[rd_ptr_q] : '0;
    instr_pc    = head_valid ? q_pc[rd_ptr_q]    : '0;
  end

  // PC, in-flight PC and squash flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      issued_pc_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end else if (gnt) begin
        pc_q <= pc_q + PC_STEP;
      end

      if (gnt) begin
        issued_pc_q <= pc_q;
      end

      if (redirect_valid) begin
        // Squash a response that is still to come: either the request is
        // being granted now, or it was granted and its data has not arrived.
        // A response arriving on the redirect edge is discarded directly.
        drop_q <= gnt || ((state_q == S_WAIT) && !imem_rvalid);
      end else if (rsp) begin
        drop_q <= 1'b0;
      end
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (redirect_valid) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_after;
    end
  end

  // Queue storage, written on push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; its contents are only observed
    // through the occupancy-gated head outputs, so stale data is never seen.
    if (push) begin
      q_instr[wr_ptr_q] <= imem_rdata;
      q_pc[wr_ptr_q]    <= issued_pc_q;
    end
  end

endmodule
